// File: rtl/instr_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_seq_pkg
// Brief  : Shared types and constants for the instruction fetch sequencer:
//          instruction width, opcode field position, default halt opcode
//          and the sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package instr_fetch_seq_pkg;

  localparam int INSTR_W = 16;

  // Opcode field inside an instruction word
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_MEM = 3'd2,
    ST_LOAD_IR  = 3'd3,
    ST_START    = 3'd4,
    ST_EXEC     = 3'd5,
    ST_HALTED   = 3'd6
  } state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_seq_pc_reg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pc_reg
// Brief  : Program counter register. Synchronous reset to RESET_PC, advances
//          by one when inc is high, wrapping modulo 2^PC_W.
// Ports  : clk   - system clock
//          reset - synchronous active-high reset
//          inc   - increment enable
//          pc    - current program counter
// Rev    : 1.0  initial release
// ============================================================================
module fetch_pc_reg #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  // Natural PC_W-bit overflow provides the wrap from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_INIT;
    end else if (inc) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_seq
// Brief  : Fetch sequencer that runs the lab CPU from instruction memory.
//          Reads the word at pc, loads it into the CPU instruction register,
//          pulses the CPU start request, waits for the controller to return
//          to its waiting state, then advances pc. A word carrying
//          HALT_OPCODE stops fetching until reset.
// Ports  : clk, reset          - clock, synchronous active-high reset
//          run                 - fetch enable
//          mem_addr/mem_read   - instruction memory address and read strobe
//          mem_rdata           - memory data, valid one cycle after address
//          ir_data/ir_load     - instruction word and load pulse to cpu
//          cpu_s/cpu_w         - cpu start request / cpu waiting flag
//          pc, instr_count     - program counter, completed instructions
//          halted              - halt opcode has been fetched
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int               PC_W        = 8,
  parameter int unsigned      RESET_PC    = 0,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_read,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_load,
  output logic               cpu_s,
  input  logic               cpu_w,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        instr_count,
  output logic               halted
);

  state_t state;
  state_t state_nxt;
  logic   pc_inc;

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are pure decodes of the state register, so no output has a
  // combinational path from mem_rdata or the cpu handshake inputs.
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    ir_load   = 1'b0;
    cpu_s     = 1'b0;
    halted    = 1'b0;
    pc_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && cpu_w) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        state_nxt = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        // Read strobe held so the synchronous RAM keeps presenting the word.
        mem_read = 1'b1;
        if (opcode_of(mem_rdata) == HALT_OPCODE) begin
          state_nxt = ST_HALTED;
        end else begin
          state_nxt = ST_LOAD_IR;
        end
      end
      ST_LOAD_IR: begin
        ir_load   = 1'b1;
        state_nxt = ST_START;
      end
      ST_START: begin
        // Hold the request until the controller acknowledges by leaving wait.
        cpu_s = 1'b1;
        if (!cpu_w) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cpu_w) begin
          pc_inc    = 1'b1;
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The halt word is captured here too, but never loaded into the cpu.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_data <= '0;
    end else if (state == ST_WAIT_MEM) begin
      ir_data <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= 16'd0;
    end else if (pc_inc && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_seq
// Brief  : Self-checking bench for instr_fetch_seq with a synchronous RAM
//          model, a responsive cpu handshake model and an instruction-level
//          reference model of the expected sequencer outputs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_seq;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [PC_W-1:0] mem_addr;
  logic            mem_read;
  logic [15:0]     mem_rdata = 16'd0;
  logic [15:0]     ir_data;
  logic            ir_load;
  logic            cpu_s;
  logic            cpu_w;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_count;
  logic            halted;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  instr_fetch_seq #(
    .PC_W        (PC_W),
    .RESET_PC    (0),
    .HALT_OPCODE (3'b111)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .ir_data     (ir_data),
    .ir_load     (ir_load),
    .cpu_s       (cpu_s),
    .cpu_w       (cpu_w),
    .pc          (pc),
    .instr_count (instr_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction RAM
  logic [15:0] mem [0:255];
  always @(posedge clk) if (mem_read) mem_rdata <= mem[mem_addr];

  // cpu handshake model: leaves wait drop_dly cycles after seeing s,
  // returns to wait rise_dly cycles later.
  int drop_dly = 1;
  int rise_dly = 3;
  int cpu_cnt  = 0;
  initial cpu_w = 1'b1;
  always @(negedge clk) begin
    if (reset) begin
      cpu_w   = 1'b1;
      cpu_cnt = 0;
    end else if (cpu_w && cpu_s) begin
      if (cpu_cnt >= drop_dly) begin cpu_w = 1'b0; cpu_cnt = 0; end
      else cpu_cnt++;
    end else if (!cpu_w) begin
      if (cpu_cnt >= rise_dly) begin cpu_w = 1'b1; cpu_cnt = 0; end
      else cpu_cnt++;
    end else begin
      cpu_cnt = 0;
    end
  end

  // Reference model. An instruction is a timeline counted from the cycle
  // after fetch begins: two read cycles, one load cycle, a start request
  // lasting until w is seen low, then execution until w is seen high.
  localparam int M_IDLE = 0, M_BUSY = 1, M_HALT = 2;
  localparam int PH_START = 3, PH_EXEC = 4;
  int              m_mode = M_IDLE;
  int              m_ph   = 0;
  logic [PC_W-1:0] m_pc   = '0;
  logic [15:0]     m_cnt  = 16'd0;
  logic [15:0]     m_ir   = 16'd0;

  always @(posedge clk) begin : model
    logic [15:0] word;
    word = mem[m_pc];
    if (reset) begin
      m_mode = M_IDLE; m_ph = 0; m_pc = '0; m_cnt = 16'd0; m_ir = 16'd0;
    end else if (m_mode == M_IDLE) begin
      if (run && cpu_w) begin m_mode = M_BUSY; m_ph = 0; end
    end else if (m_mode == M_BUSY) begin
      if (m_ph == 1) begin
        m_ir = word;
        if (word[15:13] == 3'b111) m_mode = M_HALT;
        else m_ph = 2;
      end else if (m_ph < PH_START) begin
        m_ph++;
      end else if (m_ph == PH_START) begin
        if (!cpu_w) m_ph = PH_EXEC;
      end else if (cpu_w) begin
        m_pc = m_pc + 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_ph = 0;
        if (!run) m_mode = M_IDLE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_read",    mem_read,    (m_mode == M_BUSY && m_ph <= 1));
      chk("ir_load",     ir_load,     (m_mode == M_BUSY && m_ph == 2));
      chk("cpu_s",       cpu_s,       (m_mode == M_BUSY && m_ph == PH_START));
      chk("halted",      halted,      (m_mode == M_HALT));
      chk("pc",          pc,          m_pc);
      chk("mem_addr",    mem_addr,    m_pc);
      chk("instr_count", instr_count, m_cnt);
      chk("ir_data",     ir_data,     m_ir);
    end
  end

  task automatic fill_mem(input int halt_odds);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom());
      if (halt_odds == 0 || $urandom_range(1, halt_odds) != 1)
        if (w[15:13] == 3'b111) w[15] = 1'b0;
      mem[i] = w;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run   = 1'b0;
    fill_mem(0);
    mem[0] = 16'hD105;
    mem[1] = 16'h4321;
    mem[2] = 16'hA0F0;
    mem[3] = 16'hE000;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;

    // Reset state
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_ir", ir_data, 0);
    chk("rst_strobes", {mem_read, ir_load, cpu_s, halted}, 4'b0000);

    // First instruction latency
    reset = 1'b0;
    run   = 1'b1;
    @(negedge clk); chk("c0_read", {mem_read, mem_addr}, {1'b1, 8'd0});
    @(negedge clk); chk("c1_read", mem_read, 1);
    @(negedge clk); chk("c2_load", {ir_load, ir_data}, {1'b1, 16'hD105});
    @(negedge clk); chk("c3_s", cpu_s, 1);

    n = 0;
    while (instr_count != 16'd1 && n < 100) begin @(negedge clk); n++; end
    chk("i1_count", instr_count, 1);
    chk("i1_next_fetch", {pc, mem_read, mem_addr, cpu_s}, {8'd1, 1'b1, 8'd1, 1'b0});

    // Halt word at address 3
    n = 0;
    while (!halted && n < 200) begin @(negedge clk); n++; end
    chk("halt_flag", halted, 1);
    chk("halt_state", {pc, instr_count, ir_data}, {8'd3, 16'd3, 16'hE000});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_quiet", {mem_read, cpu_s, ir_load}, 3'b000);
    end

    // run dropped during execution of address 5
    mem[3] = 16'h2003;
    do_reset();
    run = 1'b1;
    n = 0;
    while (!(ir_load && pc == 8'd5) && n < 300) begin @(negedge clk); n++; end
    chk("reach_pc5", {ir_load, pc}, {1'b1, 8'd5});
    n = 0;
    while (!cpu_s && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (cpu_s && n < 50) begin @(negedge clk); n++; end
    chk("exec_pc5", {cpu_s, pc}, {1'b0, 8'd5});
    run = 1'b0;
    n = 0;
    while (pc != 8'd6 && n < 50) begin @(negedge clk); n++; end
    chk("park_pc6", pc, 6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("park_quiet", {mem_read, cpu_s, pc}, {2'b00, 8'd6});
    end
    run = 1'b1;
    n = 0;
    while (!mem_read && n < 10) begin @(negedge clk); n++; end
    chk("resume_addr", {mem_read, mem_addr}, {1'b1, 8'd6});

    // Reset while requesting start
    n = 0;
    while (!cpu_s && n < 50) begin @(negedge clk); n++; end
    chk("in_start", cpu_s, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    chk("rst_mid", {cpu_s, pc, instr_count, halted, mem_read}, {1'b0, 8'd0, 16'd0, 1'b0, 1'b0});

    // PC wrap with a fast cpu
    drop_dly = 0;
    rise_dly = 0;
    do_reset();
    run = 1'b1;
    n = 0;
    while (instr_count != 16'd256 && n < 5000) begin @(negedge clk); n++; end
    chk("wrap_count", instr_count, 256);
    chk("wrap_pc", {pc, mem_read, mem_addr}, {8'd0, 1'b1, 8'd0});

    // Randomized traffic with occasional halts and resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 249) == 0);
      run      = ($urandom_range(0, 9) != 0);
      drop_dly = $urandom_range(0, 3);
      rise_dly = $urandom_range(0, 5);
      if (reset) fill_mem(40);
    end
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Sequencer that makes the lab CPU self-running from memory.
- Drives the PC and a synchronous instruction memory read.
- Loads each fetched word into the CPU instruction register via `load`/`in`.
- Pulses the CPU start input `s`, waits for the controller's `w` to return high, then advances the PC.
- Sits between the instruction RAM and the cpu block. It replaces the manual switch/button driving of `in`, `load` and `s`.

Parameters:
- PC_W, 8, PC and memory address width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 3'b111, opcode in bits [15:13] that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  enable; sampled in IDLE and at end of each instruction.
- mem_addr  output  PC_W  instruction memory address (equals pc).
- mem_read  output  1  memory read strobe.
- mem_rdata  input  16  memory read data; valid the cycle after the address is presented.
- ir_data  output  16  captured instruction; wired to cpu `in`.
- ir_load  output  1  one-cycle pulse; wired to cpu `load`.
- cpu_s  output  1  start request; wired to cpu `s`.
- cpu_w  input  1  cpu controller waiting flag (`w`).
- pc  output  PC_W  current program counter.
- instr_count  output  16  instructions completed.
- halted  output  1  high once HALT_OPCODE has been fetched.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, instr_count=0, ir_data=0.
  - mem_read=0, ir_load=0, cpu_s=0, halted=0.
  - Reset asserted in any state, mid-instruction included, applies all of these at the next edge.
  - Reset also overrides every other input in that cycle.
- States (one-hot or binary, implementer's choice): IDLE, FETCH, WAIT_MEM, LOAD_IR, START, EXEC, HALTED.
- IDLE: all strobes 0. Go to FETCH when run=1 and cpu_w=1; otherwise stay.
- FETCH: mem_read=1, mem_addr=pc. Always go to WAIT_MEM.
- WAIT_MEM:
  - mem_read=1; ir_data <= mem_rdata at the end of the cycle.
  - If mem_rdata[15:13]==HALT_OPCODE, go to HALTED. Otherwise go to LOAD_IR.
- LOAD_IR: ir_load=1 for exactly this cycle. Go to START.
- START:
  - cpu_s=1, held until cpu_w is sampled 0. Then go to EXEC.
  - If cpu_w never drops, remain in START indefinitely; no timeout.
- EXEC:
  - cpu_s=0. Wait for cpu_w=1.
  - On that edge: pc <= pc+1, wrapping modulo 2^PC_W (max value wraps to 0).
  - On that edge: instr_count <= instr_count+1, saturating at 16'hFFFF.
  - Next state is FETCH if run=1, else IDLE.
- HALTED:
  - halted=1, pc unchanged, all strobes 0.
  - Stays until reset; run is ignored.
  - The halt word is captured in ir_data but never loaded into the cpu, so instr_count excludes it.
- run deasserted mid-instruction: the current instruction completes and the PC increments. The block then parks in IDLE; it does not abort.
- Latency:
  - The edge leaving IDLE is edge 0.
  - ir_load is high in cycle 2 and cpu_s rises in cycle 3.
  - Minimum fetch overhead is 4 cycles per instruction beyond cpu execution time.
- mem_addr is driven combinationally from pc at all times. Only mem_read qualifies it.
- No output is combinationally dependent on mem_rdata.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - the opcode field slice constants (15:13);
  - the HALT_OPCODE default;
  - the instruction width (16).
- One natural sub-module: fetch_pc_reg. It is the PC register with synchronous reset to RESET_PC, an increment enable, and wrap.
- The FSM, capture register and counter stay in the top module.

Test Plan:
- Reset then run=1; mem holds 16'hD105 at addr 0, cpu_w=1 -> mem_read cycles 0-1, ir_data=16'hD105 and ir_load pulse in cycle 2, cpu_s high from cycle 3.
- Model cpu drops w one cycle after s, raises w 3 cycles later -> cpu_s deasserts, pc 0->1, instr_count=1, FETCH of addr 1 follows immediately.
- Three instructions then 16'hE000 at addr 3 -> halted=1, pc=3, instr_count=3, no further mem_read or cpu_s even with run=1.
- run dropped during EXEC of addr 5 -> pc becomes 6, state IDLE, no mem_read. Reassert run -> fetch resumes at addr 6.
- PC_W=8, pc preset via run from 255 -> after completion pc=0 (wrap), fetch of addr 0.
- reset pulsed while in START with cpu_s=1 -> next cycle cpu_s=0, pc=RESET_PC, instr_count=0, state IDLE, halted=0.
